// File: rtl/pipe_hazard_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Signal bundle between the decode/execute/writeback stages and
//               the hazard controller. The master side is the pipeline, which
//               drives the requests. The slave side is the hazard controller,
//               which returns stall/flush status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

  // Decode issue
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [4:0] issue_rs1;
  logic       issue_rs1_used;
  logic [4:0] issue_rs2;
  logic       issue_rs2_used;

  // Retire / squash
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       kill_valid;
  logic [4:0] kill_rd;

  // Pipeline control requests
  logic       mem_stall;
  logic       redirect_valid;

  // Controller status
  logic       stall_out;
  logic       flush_out;
  logic       pending_any;
  logic       sb_error;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs1_used,
    output issue_rs2, issue_rs2_used,
    output wb_valid, wb_rd, kill_valid, kill_rd,
    output mem_stall, redirect_valid,
    input  stall_out, flush_out, pending_any, sb_error
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs1_used,
    input  issue_rs2, issue_rs2_used,
    input  wb_valid, wb_rd, kill_valid, kill_rd,
    input  mem_stall, redirect_valid,
    output stall_out, flush_out, pending_any, sb_error
  );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Scoreboard hazard detector and flush sequencer for the in-order
//               integer pipeline. A small counter per architectural register
//               tracks writes issued but not yet retired. Decode is held while
//               a source has a pending writer, while a destination counter is
//               saturated, or while memory is busy. A redirect from execute
//               starts a FLUSH_CYCLES-long flush of fetch/decode.
// Options     : `define PHC_WB_BYPASS_EN to let a source whose last pending
//               writer retires this very cycle issue without waiting (the
//               writeback value is forwarded into decode).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int              SUM_W      = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic       sb_error_q, sb_error_d;

  logic       in_run;
  logic       flush_o;

  // Read-only view of every counter; entry 0 is the hard-wired x0 slot.
  logic [CNT_W-1:0]    cnt_view [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] underflow_vec;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic             rs1_byp, rs2_byp;
  logic             raw_rs1, raw_rs2, raw, sat;
  logic             stall_o, accept;

  // --------------------------------------------------------------------------
  // Hazard evaluation. Only registered counters feed these terms so the stall
  // path never loops back through this cycle's counter update.
  // --------------------------------------------------------------------------
  assign cnt_rs1 = cnt_view[bus.issue_rs1];
  assign cnt_rs2 = cnt_view[bus.issue_rs2];
  assign cnt_rd  = cnt_view[bus.issue_rd];

`ifdef PHC_WB_BYPASS_EN
  // A lone pending writer retiring right now can be forwarded, so it is not
  // a hazard for the reader in decode.
  assign rs1_byp = bus.wb_valid && (bus.wb_rd == bus.issue_rs1) && (cnt_rs1 == CNT_ONE);
  assign rs2_byp = bus.wb_valid && (bus.wb_rd == bus.issue_rs2) && (cnt_rs2 == CNT_ONE);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign raw_rs1 = bus.issue_rs1_used && (bus.issue_rs1 != 5'd0) &&
                   (cnt_rs1 != '0) && !rs1_byp;
  assign raw_rs2 = bus.issue_rs2_used && (bus.issue_rs2 != 5'd0) &&
                   (cnt_rs2 != '0) && !rs2_byp;
  assign raw     = raw_rs1 || raw_rs2;

  // A saturated destination cannot take another increment.
  assign sat     = (bus.issue_rd != 5'd0) && (cnt_rd == CNT_MAX);

  assign stall_o = bus.issue_valid && in_run && (raw || sat || bus.mem_stall);
  assign accept  = bus.issue_valid && in_run && !stall_o && !bus.redirect_valid;

  // --------------------------------------------------------------------------
  // Per-register pending counters
  // --------------------------------------------------------------------------
  // x0 is never written, so its slot is permanently idle.
  generate
    if (1) begin : g_x0
      assign cnt_view[0]      = '0;
      assign busy_vec[0]      = 1'b0;
      assign underflow_vec[0] = 1'b0;
    end
  endgenerate

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             inc, wb_dec, kill_dec;
      logic [SUM_W-1:0] sum;

      assign inc      = accept         && (bus.issue_rd == 5'(r));
      assign wb_dec   = bus.wb_valid   && (bus.wb_rd    == 5'(r));
      assign kill_dec = bus.kill_valid && (bus.kill_rd  == 5'(r));

      // Two's-complement sum with headroom for one increment and two decrements.
      assign sum = {2'b00, cnt_q} + SUM_W'(inc) - SUM_W'(wb_dec) - SUM_W'(kill_dec);

      // Negative results clamp to zero and are flagged; the upper saturation
      // branch is defensive, as issue is held off while the counter is full.
      always_comb begin
        cnt_d = sum[CNT_W-1:0];
        if (sum[SUM_W-1]) begin
          cnt_d = '0;
        end else if (sum[CNT_W]) begin
          cnt_d = CNT_MAX;
        end
      end

      // Counter register, cleared only by reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_view[r]      = cnt_q;
      assign busy_vec[r]      = (cnt_q != '0);
      assign underflow_vec[r] = sum[SUM_W-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flush sequencer
  // --------------------------------------------------------------------------
  // Next-state: a redirect (re)loads the remaining-cycle counter; FLUSH exits
  // once the counter has reached zero.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    in_run      = 1'b0;
    flush_o     = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_run = 1'b1;
        if (bus.redirect_valid) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (bus.redirect_valid) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // State and flush counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky scoreboard error: any counter asked to go below zero.
  // --------------------------------------------------------------------------
  assign sb_error_d = sb_error_q || (|underflow_vec);

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_error_q <= 1'b0;
    end else begin
      sb_error_q <= sb_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.stall_out   = stall_o;
  assign bus.flush_out   = flush_o;
  assign bus.pending_any = |busy_vec;
  assign bus.sb_error    = sb_error_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire
